// File: rtl/regfile_sb.sv
// Register file with per-register busy scoreboard for the 16-bit CPU decode/writeback stages.
// Two combinational read ports, optional write-to-read bypass and optional hardwired-zero r0.
module regfile_sb #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rega,
  input  logic [ADDR_W-1:0] regb,
  output logic [DATA_W-1:0] read1,
  output logic [DATA_W-1:0] read2,
  output logic              busy1,
  output logic              busy2,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] wreg,
  input  logic [DATA_W-1:0] writedata,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_reg,
  output logic              rsv_conflict,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;
  logic              conflict_next;
  logic [ADDR_W:0]   cnt_next;
  logic              wr_ok;
  logic              rsv_ok;
  logic              zero1, zero2;
  logic              hit1, hit2;

  // Requests aimed at a hardwired r0 are dropped before they touch any state.
  assign wr_ok  = write_en && !(ZERO_R0 && (wreg == '0));
  assign rsv_ok = rsv_en && !(ZERO_R0 && (rsv_reg == '0));

  // NOTE: every variable assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    busy_next = busy;
    if (wr_ok)  busy_next[wreg]    = 1'b0;
    if (rsv_ok) busy_next[rsv_reg] = 1'b1;   // reservation wins over a same-cycle clear
    conflict_next = rsv_ok && busy[rsv_reg];
    cnt_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_next = cnt_next + (ADDR_W+1)'(busy_next[i]);
    end
  end

  // NOTE: the data array is reset explicitly because a cleared register file is architecturally visible; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      busy         <= '0;
      rsv_conflict <= 1'b0;
      busy_cnt     <= '0;
    end else begin
      if (wr_ok) mem[wreg] <= writedata;
      busy         <= busy_next;
      rsv_conflict <= conflict_next;
      busy_cnt     <= cnt_next;
    end
  end

  assign zero1 = ZERO_R0 && (rega == '0);
  assign zero2 = ZERO_R0 && (regb == '0);
  assign hit1  = BYPASS && write_en && (wreg == rega);
  assign hit2  = BYPASS && write_en && (wreg == regb);

  // Bypass forwards the writeback data and its busy-clear; a same-cycle reservation is never forwarded.
  assign read1 = zero1 ? '0 : (hit1 ? writedata : mem[rega]);
  assign read2 = zero2 ? '0 : (hit2 ? writedata : mem[regb]);
  assign busy1 = !zero1 && !hit1 && busy[rega];
  assign busy2 = !zero2 && !hit2 && busy[regb];

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus queues hand-computed expectations per cycle,
// a negedge monitor pops and compares them against a bypassing and a non-bypassing instance.
module tb_regfile_sb;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;

  typedef enum logic [2:0] {
    S_READ1, S_READ2, S_BUSY1, S_BUSY2, S_CONF, S_CNT, S_NB_READ1
  } sel_e;

  typedef struct {
    int          cyc;
    sel_e        sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] rega, regb, wreg, rsv_reg;
  logic              write_en, rsv_en;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] read1, read2, nb_read1, nb_read2;
  logic              busy1, busy2, nb_busy1, nb_busy2;
  logic              rsv_conflict, nb_conflict;
  logic [ADDR_W:0]   busy_cnt, nb_cnt;

  exp_t q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_R0(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .rega(rega), .regb(regb),
    .read1(read1), .read2(read2), .busy1(busy1), .busy2(busy2),
    .write_en(write_en), .wreg(wreg), .writedata(writedata),
    .rsv_en(rsv_en), .rsv_reg(rsv_reg),
    .rsv_conflict(rsv_conflict), .busy_cnt(busy_cnt)
  );

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_R0(1'b0), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .rega(rega), .regb(regb),
    .read1(nb_read1), .read2(nb_read2), .busy1(nb_busy1), .busy2(nb_busy2),
    .write_en(write_en), .wreg(wreg), .writedata(writedata),
    .rsv_en(rsv_en), .rsv_reg(rsv_reg),
    .rsv_conflict(nb_conflict), .busy_cnt(nb_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input sel_e s, input logic [31:0] v, input string name);
    exp_t e;
    e.cyc  = cyc;
    e.sel  = s;
    e.val  = v;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic idle();
    write_en = 1'b0;
    rsv_en   = 1'b0;
  endtask

  // Monitor: compare every expectation stamped for the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t        e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.sel)
        S_READ1:    act = 32'(read1);
        S_READ2:    act = 32'(read2);
        S_BUSY1:    act = 32'(busy1);
        S_BUSY2:    act = 32'(busy2);
        S_CONF:     act = 32'(rsv_conflict);
        S_CNT:      act = 32'(busy_cnt);
        S_NB_READ1: act = 32'(nb_read1);
        default:    act = 32'hDEAD_BEEF;
      endcase
      total++;
      if (e.cyc < cyc) begin
        bad++;
        $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
      end else if (act !== e.val) begin
        bad++;
        $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", e.name, act, e.val, cyc);
      end
    end
  end

  initial begin
    rst = 1'b1; rega = '0; regb = '0; wreg = '0; rsv_reg = '0;
    write_en = 1'b0; rsv_en = 1'b0; writedata = '0;
    tick(); tick();
    rst = 1'b0;

    // Load r3, then reset must wipe it.
    write_en = 1'b1; wreg = 3'd3; writedata = 16'h1234; rega = 3'd3;
    exp_push(S_READ1, 32'h1234, "r3_bypass");
    exp_push(S_NB_READ1, 32'h0, "r3_nobypass_old");
    tick();
    idle(); regb = 3'd3;
    exp_push(S_READ1, 32'h1234, "r3_stored_a");
    exp_push(S_READ2, 32'h1234, "r3_stored_b");
    exp_push(S_NB_READ1, 32'h1234, "r3_nobypass_new");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_push(S_CNT, 32'h0, "rst_cnt");
    exp_push(S_CONF, 32'h0, "rst_conf");
    for (int a = 0; a < 8; a++) begin
      rega = 3'(a); regb = 3'(7 - a);
      exp_push(S_READ1, 32'h0, $sformatf("rst_read1_r%0d", a));
      exp_push(S_READ2, 32'h0, $sformatf("rst_read2_r%0d", 7 - a));
      tick();
    end

    // Bypass vs non-bypass on r5.
    write_en = 1'b1; wreg = 3'd5; writedata = 16'hBEEF; rega = 3'd5;
    exp_push(S_READ1, 32'hBEEF, "r5_bypass");
    exp_push(S_NB_READ1, 32'h0, "r5_nobypass_old");
    tick();
    idle();
    exp_push(S_READ1, 32'hBEEF, "r5_after");
    exp_push(S_NB_READ1, 32'hBEEF, "r5_nobypass_after");
    tick();

    // Scoreboard lifecycle on r2.
    rsv_en = 1'b1; rsv_reg = 3'd2; rega = 3'd2;
    exp_push(S_BUSY1, 32'h0, "r2_rsv_not_forwarded");
    exp_push(S_CNT, 32'h0, "r2_cnt_before");
    tick();
    idle();
    exp_push(S_BUSY1, 32'h1, "r2_busy");
    exp_push(S_CNT, 32'h1, "r2_cnt_1");
    tick();
    write_en = 1'b1; wreg = 3'd2; writedata = 16'h0007;
    exp_push(S_BUSY1, 32'h0, "r2_busy_bypass_clear");
    exp_push(S_READ1, 32'h7, "r2_data_bypass");
    tick();
    idle();
    exp_push(S_CNT, 32'h0, "r2_cnt_0");
    exp_push(S_READ1, 32'h7, "r2_data");
    exp_push(S_BUSY1, 32'h0, "r2_idle");
    tick();

    // Write + reserve on an already-busy r4.
    rsv_en = 1'b1; rsv_reg = 3'd4; rega = 3'd4;
    tick();
    idle();
    exp_push(S_CNT, 32'h1, "r4_cnt_1");
    write_en = 1'b1; wreg = 3'd4; writedata = 16'hA5A5;
    rsv_en = 1'b1; rsv_reg = 3'd4;
    exp_push(S_BUSY1, 32'h0, "r4_busy_bypass");
    exp_push(S_CONF, 32'h0, "r4_conf_before");
    tick();
    idle();
    exp_push(S_BUSY1, 32'h1, "r4_busy_kept");
    exp_push(S_READ1, 32'hA5A5, "r4_data");
    exp_push(S_CNT, 32'h1, "r4_cnt_same");
    exp_push(S_CONF, 32'h1, "r4_waw_conf");
    tick();
    exp_push(S_CONF, 32'h0, "r4_conf_pulse_end");
    write_en = 1'b1; wreg = 3'd4; writedata = 16'h0001;
    tick();
    idle();
    exp_push(S_CNT, 32'h0, "r4_released");

    // Clearing a never-reserved register is harmless.
    write_en = 1'b1; wreg = 3'd6; writedata = 16'h0066;
    tick();
    idle();
    exp_push(S_CNT, 32'h0, "spurious_clear_cnt");

    // Hardwired r0: write and reserve twice.
    rega = 3'd0;
    write_en = 1'b1; wreg = 3'd0; writedata = 16'hFFFF;
    rsv_en = 1'b1; rsv_reg = 3'd0;
    exp_push(S_READ1, 32'h0, "r0_no_bypass");
    exp_push(S_BUSY1, 32'h0, "r0_busy_now");
    tick();
    write_en = 1'b0;
    exp_push(S_READ1, 32'h0, "r0_read");
    exp_push(S_BUSY1, 32'h0, "r0_busy");
    exp_push(S_CNT, 32'h0, "r0_cnt");
    tick();
    idle();
    exp_push(S_CONF, 32'h0, "r0_no_conf");
    exp_push(S_CNT, 32'h0, "r0_cnt_again");
    tick();

    // Full scoreboard, then reset mid-burst.
    for (int i = 1; i < 8; i++) begin
      rsv_en = 1'b1; rsv_reg = 3'(i);
      tick();
      exp_push(S_CNT, 32'(i), $sformatf("burst_cnt_%0d", i));
      exp_push(S_CONF, 32'h0, $sformatf("burst_conf_%0d", i));
    end
    rsv_reg = 3'd1;
    tick();
    rsv_reg = 3'd5; rst = 1'b1;
    exp_push(S_CONF, 32'h1, "burst_waw_conf");
    exp_push(S_CNT, 32'h7, "burst_cnt_full");
    tick();
    rst = 1'b0; idle();
    rega = 3'd5; regb = 3'd1;
    exp_push(S_CNT, 32'h0, "midrst_cnt");
    exp_push(S_CONF, 32'h0, "midrst_conf");
    exp_push(S_BUSY1, 32'h0, "midrst_busy_r5");
    exp_push(S_BUSY2, 32'h0, "midrst_busy_r1");
    tick();

    // Drain the scoreboard with a bounded wait.
    for (int n = 0; n < 10 && q.size() > 0; n++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      bad += q.size();
      total += q.size();
      $display("FAIL drain: %0d expectations never compared, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
